// File: rtl/ifm_window_reader.sv
// IFM window reader: walks every stride-1 output position and every channel,
// reads a KxK window out of the IFM array over two read ports, and presents
// it to the convolution unit on a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, begins a frame walk from IDLE
//   busy, done            frame in progress / one-cycle end-of-frame pulse
//   ifm_sel               channel select to the IFM array
//   ifm_enable_read_*     port A/B read enables
//   ifm_address_read_*    port A/B read addresses (0 while disabled)
//   data_in_A/B           read data, valid one cycle after the enable
//   window_data           KxK pixels, slot k = kr*K+kc at [k*DW +: DW]
//   window_valid/ready    window handshake
//   window_last_ifm       window belongs to the last channel
//   window_last           final window of the frame
module ifm_window_reader #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 14,
    parameter int NUMBER_OF_IFM    = 2,
    parameter int KERNEL_SIZE      = 3,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE),
    parameter int SEL_WIDTH        = (NUMBER_OF_IFM > 1) ?
                                     $clog2(NUMBER_OF_IFM) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic [SEL_WIDTH-1:0]                      ifm_sel,
    output logic                                      ifm_enable_read_A_next,
    output logic                                      ifm_enable_read_B_next,
    output logic [ADDRESS_SIZE_IFM-1:0]               ifm_address_read_A_next,
    output logic [ADDRESS_SIZE_IFM-1:0]               ifm_address_read_B_next,
    input  logic [DATA_WIDTH-1:0]                     data_in_A,
    input  logic [DATA_WIDTH-1:0]                     data_in_B,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_data,
    output logic                                      window_valid,
    input  logic                                      window_ready,
    output logic                                      window_last_ifm,
    output logic                                      window_last
);

    localparam int OUT  = IFM_SIZE - KERNEL_SIZE + 1;
    localparam int NPIX = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NRD  = (NPIX + 1) / 2;
    localparam int OW   = $clog2(OUT + 1);
    localparam int KW   = $clog2(KERNEL_SIZE + 1);
    localparam int JW   = (NRD > 1) ? $clog2(NRD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [OW-1:0]           r_row;
    logic [OW-1:0]           r_col;
    logic [SEL_WIDTH-1:0]    r_ch;
    logic [JW-1:0]           r_rd_idx;
    logic [KW-1:0]           r_kr_a;
    logic [KW-1:0]           r_kc_a;
    logic                    r_cap_vld;
    logic [JW-1:0]           r_cap_idx;
    logic [DATA_WIDTH-1:0]   r_win [NPIX];

    logic [KW-1:0]           w_kr_b;
    logic [KW-1:0]           w_kc_b;
    logic [KW-1:0]           w_kr_n;
    logic [KW-1:0]           w_kc_n;
    logic                    w_en_a;
    logic                    w_en_b;
    logic                    w_b_in_range;
    logic                    w_hs;
    logic                    w_last_ch;
    logic                    w_last_win;
    logic [ADDRESS_SIZE_IFM-1:0] w_addr_a;
    logic [ADDRESS_SIZE_IFM-1:0] w_addr_b;

    // Port B reads the pixel after port A in raster order; the next
    // cycle's port A pixel is the one after that.
    always_comb begin
        w_kr_b = r_kr_a;
        w_kc_b = r_kc_a + 1'b1;
        if (int'(r_kc_a) == KERNEL_SIZE - 1) begin
            w_kr_b = r_kr_a + 1'b1;
            w_kc_b = '0;
        end
        w_kr_n = w_kr_b;
        w_kc_n = w_kc_b + 1'b1;
        if (int'(w_kc_b) == KERNEL_SIZE - 1) begin
            w_kr_n = w_kr_b + 1'b1;
            w_kc_n = '0;
        end
    end

    assign w_addr_a = ADDRESS_SIZE_IFM'(
        (int'(r_row) + int'(r_kr_a)) * IFM_SIZE + int'(r_col) + int'(r_kc_a));
    assign w_addr_b = ADDRESS_SIZE_IFM'(
        (int'(r_row) + int'(w_kr_b)) * IFM_SIZE + int'(r_col) + int'(w_kc_b));

    assign w_b_in_range = (2 * int'(r_rd_idx) + 1) < NPIX;
    assign w_last_ch    = int'(r_ch) == NUMBER_OF_IFM - 1;
    assign w_last_win   = w_last_ch &&
                          int'(r_col) == OUT - 1 &&
                          int'(r_row) == OUT - 1;
    assign w_hs         = (r_state == S_PRESENT) && window_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        busy            = 1'b1;
        done            = 1'b0;
        window_valid    = 1'b0;
        window_last_ifm = 1'b0;
        window_last     = 1'b0;
        w_en_a          = 1'b0;
        w_en_b          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_READ;
            end
            S_READ: begin
                w_en_a = 1'b1;
                w_en_b = w_b_in_range;
                if (int'(r_rd_idx) == NRD - 1) w_next = S_FLUSH;
            end
            S_FLUSH: w_next = S_PRESENT;
            S_PRESENT: begin
                window_valid    = 1'b1;
                window_last_ifm = w_last_ch;
                window_last     = w_last_win;
                if (window_ready) w_next = w_last_win ? S_DONE : S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign ifm_enable_read_A_next  = w_en_a;
    assign ifm_enable_read_B_next  = w_en_b;
    // The array ORs its address sources, so idle ports must drive 0.
    assign ifm_address_read_A_next = w_en_a ? w_addr_a : '0;
    assign ifm_address_read_B_next = w_en_b ? w_addr_b : '0;
    assign ifm_sel                 = r_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row    <= '0;
            r_col    <= '0;
            r_ch     <= '0;
            r_rd_idx <= '0;
            r_kr_a   <= '0;
            r_kc_a   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row    <= '0;
                        r_col    <= '0;
                        r_ch     <= '0;
                        r_rd_idx <= '0;
                        r_kr_a   <= '0;
                        r_kc_a   <= '0;
                    end
                end
                S_READ: begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                    r_kr_a   <= w_kr_n;
                    r_kc_a   <= w_kc_n;
                end
                S_PRESENT: begin
                    if (w_hs) begin
                        r_rd_idx <= '0;
                        r_kr_a   <= '0;
                        r_kc_a   <= '0;
                        if (w_last_ch) begin
                            r_ch <= '0;
                            if (int'(r_col) == OUT - 1) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data arrives one cycle after issue; remember which read pair
    // it belongs to so it lands in the right slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            for (int k = 0; k < NPIX; k++) r_win[k] <= '0;
        end else begin
            r_cap_vld <= (r_state == S_READ);
            r_cap_idx <= r_rd_idx;
            if (r_cap_vld) begin
                for (int k = 0; k < NPIX; k++) begin
                    if (k == 2 * int'(r_cap_idx))
                        r_win[k] <= data_in_A;
                    else if (k == 2 * int'(r_cap_idx) + 1)
                        r_win[k] <= data_in_B;
                end
            end
        end
    end

    for (genvar g = 0; g < NPIX; g++) begin : g_win
        assign window_data[g*DATA_WIDTH +: DATA_WIDTH] = r_win[g];
    end

endmodule

// File: tb/tb_ifm_window_reader.sv
// Bench for ifm_window_reader: memory model returns {ch, address}, a
// position/channel reference model predicts every read and window.
module tb_ifm_window_reader;

    localparam int DW    = 32;
    localparam int S     = 14;
    localparam int N     = 2;
    localparam int K     = 3;
    localparam int AW    = $clog2(S*S);
    localparam int SW    = (N > 1) ? $clog2(N) : 1;
    localparam int OUT   = S - K + 1;
    localparam int NPIX  = K * K;
    localparam int NRD   = (NPIX + 1) / 2;
    localparam int TOTAL = OUT * OUT * N;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [SW-1:0]        ifm_sel;
    logic                 enA;
    logic                 enB;
    logic [AW-1:0]        addrA;
    logic [AW-1:0]        addrB;
    logic [DW-1:0]        data_in_A;
    logic [DW-1:0]        data_in_B;
    logic [NPIX*DW-1:0]   window_data;
    logic                 window_valid;
    logic                 window_ready;
    logic                 window_last_ifm;
    logic                 window_last;

    ifm_window_reader #(
        .DATA_WIDTH(DW), .IFM_SIZE(S), .NUMBER_OF_IFM(N), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ifm_sel(ifm_sel),
        .ifm_enable_read_A_next(enA), .ifm_enable_read_B_next(enB),
        .ifm_address_read_A_next(addrA), .ifm_address_read_B_next(addrB),
        .data_in_A(data_in_A), .data_in_B(data_in_B),
        .window_data(window_data), .window_valid(window_valid),
        .window_ready(window_ready), .window_last_ifm(window_last_ifm),
        .window_last(window_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int ch, input int a);
        return (DW'(ch) << 16) | DW'(a);
    endfunction

    function automatic int exp_addr(input int n, input int k);
        int r, c;
        r = n / (OUT * N);
        c = (n / N) % OUT;
        return (r + k / K) * S + c + k % K;
    endfunction

    // Garbage when not enabled so mistimed capture is visible.
    always @(posedge clk) begin
        data_in_A <= enA ? word(int'(ifm_sel), int'(addrA)) : $urandom;
        data_in_B <= enB ? word(int'(ifm_sel), int'(addrB)) : $urandom;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int start_cyc = 0;
    int win_idx  = 0;
    int rd_j     = 0;
    int n_hs     = 0;
    int n_done   = 0;
    bit in_frame = 0;
    bit prev_hs  = 0;
    bit prev_fin = 0;
    bit seen0    = 0;
    logic [NPIX*DW-1:0] fin_data;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sel"}, ifm_sel, 0);
        chk({tag, "_enA"}, enA, 0);
        chk({tag, "_enB"}, enB, 0);
        chk({tag, "_addrA"}, addrA, 0);
        chk({tag, "_addrB"}, addrB, 0);
        chk({tag, "_valid"}, window_valid, 0);
        chk({tag, "_lastifm"}, window_last_ifm, 0);
        chk({tag, "_last"}, window_last, 0);
        chk({tag, "_wdata"}, window_data == '0, 1);
    endtask

    task automatic tick(input bit rdy, input bit stp);
        bit hs;
        bit fin;
        @(negedge clk);
        ncyc++;
        chk("busy", busy, in_frame);
        chk("done", done, prev_fin);
        if (prev_fin) in_frame = 0;
        if (prev_hs && !prev_fin) chk("read_after_hs", enA, 1);
        if (in_frame && ncyc == start_cyc + 1) chk("first_read", enA, 1);
        if (!enA) chk("addrA_idle", addrA, 0);
        if (!enB) chk("addrB_idle", addrB, 0);
        if (!in_frame) begin
            chk("valid_idle", window_valid, 0);
            chk("enA_idle", enA, 0);
        end
        if (enA) begin
            chk("rd_in_range", rd_j < NRD, 1);
            chk("rd_sel", ifm_sel, win_idx % N);
            chk("rd_addrA", addrA, exp_addr(win_idx, 2 * rd_j));
            chk("rd_enB", enB, (2 * rd_j + 1) < NPIX);
            if (enB) chk("rd_addrB", addrB, exp_addr(win_idx, 2 * rd_j + 1));
            rd_j++;
        end
        if (window_valid) begin
            chk("valid_after_reads", rd_j, NRD);
            chk("no_read_pending", enA | enB, 0);
            chk("valid_in_frame", win_idx < TOTAL, 1);
            if (win_idx == 0 && !seen0) begin
                seen0 = 1;
                chk("latency", ncyc - start_cyc, NRD + 2);
            end
            if (win_idx < TOTAL) begin
                chk("win_sel", ifm_sel, win_idx % N);
                chk("win_last_ifm", window_last_ifm, (win_idx % N) == N - 1);
                chk("win_last", window_last, win_idx == TOTAL - 1);
                for (int k = 0; k < NPIX; k++)
                    chk($sformatf("win%0d_slot%0d", win_idx, k),
                        window_data[k*DW +: DW],
                        word(win_idx % N, exp_addr(win_idx, k)));
            end
        end
        start        = stp;
        window_ready = rdy;
        hs  = window_valid && rdy;
        fin = hs && (win_idx == TOTAL - 1);
        if (stp && !in_frame) begin
            in_frame  = 1;
            start_cyc = ncyc;
            win_idx   = 0;
            rd_j      = 0;
            seen0     = 0;
        end
        if (hs) begin
            if (fin) fin_data = window_data;
            win_idx++;
            rd_j = 0;
            n_hs++;
        end
        if (done) n_done++;
        prev_hs  = hs;
        prev_fin = fin;
    endtask

    int tbl0 [NPIX] = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
    int tblF [NPIX] = '{165, 166, 167, 179, 180, 181, 193, 194, 195};

    initial begin
        int guard;
        rst_n        = 1'b0;
        start        = 1'b0;
        window_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick(0, 0);

        // First window, held with ready low for 10 valid cycles.
        tick(0, 1);
        repeat (16) tick(0, 0);
        chk("hold_valid", window_valid, 1);
        for (int k = 0; k < NPIX; k++)
            chk($sformatf("w0_tbl%0d", k), window_data[k*DW +: DW],
                word(0, tbl0[k]));
        chk("w0_last_ifm", window_last_ifm, 0);

        // Rest of the frame: random ready, stray start pulses while busy.
        guard = 0;
        while (in_frame && guard < 6000) begin
            tick($urandom_range(0, 3) != 0,
                 (win_idx < TOTAL) && ($urandom_range(0, 15) == 0));
            guard++;
        end
        chk("frame_finished", in_frame, 0);
        chk("hs_count", n_hs, TOTAL);
        chk("done_count", n_done, 1);
        for (int k = 0; k < NPIX; k++)
            chk($sformatf("final_tbl%0d", k), fin_data[k*DW +: DW],
                word(N - 1, tblF[k]));
        repeat (4) tick(0, 0);

        // Reset in the middle of window 3's reads.
        tick(0, 1);
        guard = 0;
        while (!(win_idx == 3 && rd_j == 2) && guard < 200) begin
            tick(1, 0);
            guard++;
        end
        chk("reached_w3_read", rd_j, 2);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(posedge clk);
        #1 chk_zero("rst_hold");
        @(negedge clk);
        rst_n    = 1'b1;
        in_frame = 0;
        prev_hs  = 0;
        prev_fin = 0;
        win_idx  = 0;
        rd_j     = 0;
        n_done   = 0;
        repeat (5) tick(1, 0);
        chk("post_rst_idle_done", n_done, 0);

        tick(0, 1);
        guard = 0;
        while (win_idx < 1 && guard < 40) begin
            tick(1, 0);
            guard++;
        end
        chk("restart_window0", win_idx, 1);
        chk("restart_seen", seen0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ifm_window_reader.md
Name: ifm_window_reader

Overview:
- Downstream consumer of the IFM memory array.
- Drives the array's next-layer read side: ifm_sel, the A/B read enables and the A/B read addresses. Captures the returned pixels into one full KERNEL_SIZE x KERNEL_SIZE window.
- Presents the window to the convolution unit over a valid/ready handshake.
- Walks every output position (stride 1, no padding). Within each position it walks every IFM channel.

Parameters:
- DATA_WIDTH, 32, pixel width.
- IFM_SIZE, 14, IFM height and width.
- NUMBER_OF_IFM, 2, channels held in the array; each is selected via ifm_sel.
- KERNEL_SIZE, 3, window height and width.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), read address width.
- SEL_WIDTH, max(1,$clog2(NUMBER_OF_IFM)), ifm_sel width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a full frame walk.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final window handshake.
- ifm_sel  out  SEL_WIDTH  channel select to the memory array.
- ifm_enable_read_A_next  out  1  port A read enable.
- ifm_enable_read_B_next  out  1  port B read enable.
- ifm_address_read_A_next  out  ADDRESS_SIZE_IFM  port A address.
- ifm_address_read_B_next  out  ADDRESS_SIZE_IFM  port B address.
- data_in_A  in  DATA_WIDTH  port A read data; valid 1 cycle after enable.
- data_in_B  in  DATA_WIDTH  port B read data; valid 1 cycle after enable.
- window_data  out  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  pixel k = kr*KERNEL_SIZE+kc occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- window_valid  out  1  window_data is valid.
- window_ready  in  1  consumer accepts the window.
- window_last_ifm  out  1  the window belongs to channel NUMBER_OF_IFM-1 (close of the channel accumulation).
- window_last  out  1  the window is the final window of the frame.

Behaviour:
- Reset is asynchronous and active-low. It applies to clock clk only.
- While rst_n is low, all outputs are 0, the FSM is IDLE and all counters are 0. This applies mid-operation too: no partial window survives, and there is no done pulse.
- OUT = IFM_SIZE-KERNEL_SIZE+1. NPIX = KERNEL_SIZE*KERNEL_SIZE. NRD = ceil(NPIX/2).
- Iteration order: row r in 0..OUT-1 (outer), then column c in 0..OUT-1, then channel ch in 0..NUMBER_OF_IFM-1 (inner).
- ifm_sel = ch. It is held constant from the first read issue of a window through its handshake.
- FSM states: IDLE, READ, FLUSH, PRESENT, DONE.
  - IDLE: when start=1, clear r/c/ch and go to READ. start is ignored in every other state.
  - READ: lasts NRD cycles; cycle j issues pixel 2j on port A and pixel 2j+1 on port B.
    - Address of pixel k = (r+kr)*IFM_SIZE + (c+kc).
    - kr/kc are tracked by incrementing counters, not by division.
    - When NPIX is odd, port B enable is 0 in the final READ cycle.
  - FLUSH: 1 cycle. Captures the last returned data. Data returned in cycle t+1 is written into window slot k at the end of cycle t+1.
  - PRESENT: window_valid=1, with window_data, window_last_ifm and window_last all stable until window_ready=1.
    - On handshake, advance ch, then c, then r.
    - Go to READ, or go to DONE if this was the final window.
  - DONE: done=1 for one cycle, busy=0 next, then return to IDLE.
- Port hygiene: whenever an enable is 0, its address output must be 0. The memory array ORs address sources, so this is mandatory.
- No read is issued while a window is pending; there is no prefetch.
- Latency, with start sampled at edge 0: READ occupies cycles 1..NRD, FLUSH occupies cycle NRD+1, and window_valid is high from cycle NRD+2. Default is cycle 7.
- Window period with ready held high: NRD+2 cycles.
- Total windows per frame = OUT*OUT*NUMBER_OF_IFM. Default is 288.
- window_ready while window_valid=0 is ignored.
- busy is high in READ, FLUSH, PRESENT and DONE.

Test Plan:
- Memory model returns data = {ch, address}. Pulse start. Expect:
  - first window at cycle 7 with ifm_sel=0;
  - slots 0..8 = addresses 0,1,2,14,15,16,28,29,30;
  - window_last_ifm=0.
  - The second window has ifm_sel=1 with the same addresses and window_last_ifm=1.
- Hold window_ready=0 for 10 cycles on the first window. Expect window_valid and window_data stable, and both read enables 0 throughout. After release, the next read issues in the following cycle.
- Full frame with ready=1. Expect:
  - exactly 288 handshakes;
  - final window at r=11, c=11, ch=1 with addresses 165,166,167,179,180,181,193,194,195;
  - window_last=1;
  - done one cycle after its handshake;
  - busy low thereafter.
- In every READ cycle 5: ifm_enable_read_B_next=0 and ifm_address_read_B_next=0. At all times: any disabled port has address 0.
- Pulse start again while busy. Expect no restart and an unchanged window count.
- Assert rst_n=0 during READ of window 3. Expect all outputs 0 immediately. After release, nothing happens until a new start, and that start returns window 0 at cycle 7.
